// File: rtl/mel_pkg.sv
// Shared STFT front-end definitions: scheduler state encoding, default window/hop
// sizes used by both the circular buffer and the frame scheduler, and the width helper.
package mel_pkg;

    localparam int WIN_LENGTH_DEF = 480;
    localparam int HOP_LENGTH_DEF = 160;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_INIT  = 3'd2,
        ST_READ  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Buffer occupancy width: clog2(2**clog2(n)) collapses to clog2(n), floored at 1 bit.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stft_frame_sched.sv
// Frame scheduler for the STFT sample buffer: primes a full window, pulses frame-init, reads one hop.
// Tags follow buf_rd_en by one cycle; dn_ready is a one-cycle credit gating each read.
module stft_frame_sched
    import mel_pkg::*;
#(
    parameter int WIN_LENGTH = WIN_LENGTH_DEF,
    parameter int HOP_LENGTH = HOP_LENGTH_DEF,
    parameter int FCNT_WIDTH = 16,
    localparam int ADDR_WIDTH = addr_width(WIN_LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] buf_count,
    input  logic                  buf_empty,
    input  logic                  buf_full,
    input  logic                  src_wr,
    input  logic                  dn_ready,
    input  logic                  err_clr,
    output logic                  buf_frm_init,
    output logic                  buf_rd_en,
    output logic                  smp_valid,
    output logic                  smp_sop,
    output logic                  smp_eop,
    output logic [FCNT_WIDTH-1:0] frm_cnt,
    output logic                  busy,
    output logic                  ovf_err
);

    localparam logic [ADDR_WIDTH-1:0] HOP_LAST = ADDR_WIDTH'(HOP_LENGTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] hop_q, hop_d;
    logic [FCNT_WIDTH-1:0] frm_cnt_q, frm_cnt_d;
    logic                  vld_q, sop_q, eop_q;
    logic                  ovf_q, ovf_d;
    logic                  rd_en, frm_init, win_ready;

    assign win_ready = 32'(buf_count) >= 32'(WIN_LENGTH);

    always_comb begin
        state_d   = state_q;
        hop_d     = hop_q;
        frm_cnt_d = frm_cnt_q;
        rd_en     = 1'b0;
        frm_init  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                if (!en)            state_d = ST_IDLE;
                else if (win_ready) state_d = ST_INIT;
            end
            ST_INIT: begin
                frm_init = 1'b1;
                hop_d    = '0;
                state_d  = ST_READ;
            end
            ST_READ: begin
                // en is deliberately ignored here so a started frame always completes
                rd_en = dn_ready & ~buf_empty;
                if (rd_en) begin
                    hop_d = hop_q + ADDR_WIDTH'(1);
                    if (hop_q == HOP_LAST) state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                frm_cnt_d = frm_cnt_q + FCNT_WIDTH'(1);
                state_d   = en ? ST_PRIME : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A new overflow in the same cycle as err_clr keeps the flag set
    assign ovf_d = (src_wr & buf_full) | (ovf_q & ~err_clr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hop_q     <= '0;
            frm_cnt_q <= '0;
            vld_q     <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hop_q     <= hop_d;
            frm_cnt_q <= frm_cnt_d;
            vld_q     <= rd_en;
            sop_q     <= rd_en & (hop_q == '0);
            eop_q     <= rd_en & (hop_q == HOP_LAST);
            ovf_q     <= ovf_d;
        end
    end

    assign buf_frm_init = frm_init;
    assign buf_rd_en    = rd_en;
    assign smp_valid    = vld_q;
    assign smp_sop      = sop_q;
    assign smp_eop      = eop_q;
    assign frm_cnt      = frm_cnt_q;
    assign busy         = (state_q != ST_IDLE);
    assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_stft_frame_sched.sv
// Bench for stft_frame_sched: default instance paired with a behavioural circular buffer,
// plus a small HOP_LENGTH=1 instance driven directly.
module tb_stft_frame_sched;

    localparam int WIN = 480;
    localparam int HOP = 160;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        src_wr = 1'b0;
    logic [15:0] src_dat = '0;
    logic        dn_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        force_full = 1'b0;

    logic [8:0]  buf_count;
    logic        buf_empty, buf_full, wr_acc;
    logic        buf_frm_init, buf_rd_en, smp_valid, smp_sop, smp_eop, busy, ovf_err;
    logic [15:0] frm_cnt;

    logic        h1_en = 1'b0;
    logic [2:0]  h1_count = 3'd6;
    logic        h1_frm_init, h1_rd_en, h1_valid, h1_sop, h1_eop, h1_busy, h1_ovf;
    logic [15:0] h1_frm_cnt;

    logic [15:0] mem [0:WIN-1];
    logic [15:0] dout = '0;
    int          wp = 0, rp = 0, cnt = 0;

    int          checks = 0, errors = 0;
    int          cyc = 0, rd_cnt = 0, init_cnt = 0, init_viol = 0, rd_viol = 0;
    logic [17:0] vq [$];
    int          wr_seq = 0;

    always #5 clk = ~clk;

    stft_frame_sched #(.WIN_LENGTH(WIN), .HOP_LENGTH(HOP), .FCNT_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .buf_count(buf_count), .buf_empty(buf_empty),
        .buf_full(buf_full), .src_wr(src_wr), .dn_ready(dn_ready), .err_clr(err_clr),
        .buf_frm_init(buf_frm_init), .buf_rd_en(buf_rd_en), .smp_valid(smp_valid),
        .smp_sop(smp_sop), .smp_eop(smp_eop), .frm_cnt(frm_cnt), .busy(busy), .ovf_err(ovf_err)
    );

    stft_frame_sched #(.WIN_LENGTH(6), .HOP_LENGTH(1), .FCNT_WIDTH(16)) u_h1 (
        .clk(clk), .rst_n(rst_n), .en(h1_en), .buf_count(h1_count), .buf_empty(1'b0),
        .buf_full(1'b0), .src_wr(1'b0), .dn_ready(1'b1), .err_clr(1'b0),
        .buf_frm_init(h1_frm_init), .buf_rd_en(h1_rd_en), .smp_valid(h1_valid),
        .smp_sop(h1_sop), .smp_eop(h1_eop), .frm_cnt(h1_frm_cnt), .busy(h1_busy), .ovf_err(h1_ovf)
    );

    // Behavioural circular buffer with registered dout
    assign buf_count = cnt[8:0];
    assign buf_empty = (cnt == 0);
    assign buf_full  = (cnt == WIN) | force_full;
    assign wr_acc    = src_wr & ~buf_full;

    always @(posedge clk) begin
        if (wr_acc) begin
            mem[wp] <= src_dat;
            wp      <= (wp == WIN - 1) ? 0 : wp + 1;
        end
        if (buf_rd_en) begin
            dout <= mem[rp];
            rp   <= (rp == WIN - 1) ? 0 : rp + 1;
        end
        cnt <= cnt + (wr_acc ? 1 : 0) - (buf_rd_en ? 1 : 0);
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (smp_valid) vq.push_back({smp_sop, smp_eop, dout});
        if (buf_rd_en) rd_cnt <= rd_cnt + 1;
        if (buf_rd_en && !dn_ready) rd_viol <= rd_viol + 1;
        if (buf_frm_init) begin
            init_cnt <= init_cnt + 1;
            if (buf_count < 9'(WIN)) init_viol <= init_viol + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr_n(input int n);
        src_wr = 1'b1;
        repeat (n) begin
            src_dat = 16'(wr_seq);
            step();
            wr_seq++;
        end
        src_wr = 1'b0;
    endtask

    task automatic wait_frm(input int target, input string tag);
        int n = 0;
        while (frm_cnt != 16'(target) && n < 3000) begin
            step();
            n++;
        end
        chk(tag, 32'(frm_cnt), 32'(target));
    endtask

    // Checks one frame captured from index vb: length, sequence, sop/eop placement
    task automatic chk_frame(input int vb, input int first, input string tag);
        int bad = 0;
        chk({tag, "_len"}, 32'(vq.size() - vb), 32'(HOP));
        if (vq.size() - vb >= HOP) begin
            for (int i = 0; i < HOP; i++) begin
                if (vq[vb + i][15:0] != 16'(first + i)) bad++;
                if (vq[vb + i][17] != (i == 0)) bad++;
                if (vq[vb + i][16] != (i == HOP - 1)) bad++;
            end
            chk({tag, "_first"}, 32'(vq[vb]), {14'd0, 2'b10, 16'(first)});
            chk({tag, "_last"}, 32'(vq[vb + HOP - 1]), {14'd0, 2'b01, 16'(first + HOP - 1)});
        end else begin
            bad = 1;
        end
        chk({tag, "_seq_bad"}, 32'(bad), 0);
    endtask

    initial begin
        int vb, ib, rb, vwb, n, seen;
        logic [1:0] se;

        // Reset state
        dn_ready = 1'b1;
        step();
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frm_cnt", 32'(frm_cnt), 0);
        chk("rst_rd_en", 32'(buf_rd_en), 0);
        chk("rst_valid", 32'(smp_valid), 0);
        chk("rst_init", 32'(buf_frm_init), 0);
        chk("rst_ovf", 32'(ovf_err), 0);
        rst_n = 1'b1;

        // 1: basic frame
        en = 1'b1;
        vb = vq.size();
        ib = init_cnt;
        wr_n(WIN);
        wait_frm(1, "s1_frm_cnt");
        step();
        chk("s1_init_pulses", 32'(init_cnt - ib), 1);
        chk_frame(vb, 0, "s1");
        chk("s1_count", 32'(buf_count), 320);
        chk("s1_busy_prime", 32'(busy), 1);

        // 2: steady state, four more frames
        for (int k = 1; k <= 4; k++) begin
            vb = vq.size();
            wr_n(HOP);
            wait_frm(1 + k, "s2_frm_cnt");
            step();
            chk_frame(vb, HOP * k, "s2");
        end
        chk("s2_frm_cnt5", 32'(frm_cnt), 5);
        chk("s2_init_viol", 32'(init_viol), 0);

        // 3: backpressure, dn_ready 1 on / 2 off
        vb = vq.size();
        rb = rd_cnt;
        vwb = rd_viol;
        wr_n(HOP);
        n = 0;
        while (frm_cnt != 16'd6 && n < 2000) begin
            dn_ready = (n % 3 == 0);
            step();
            n++;
        end
        dn_ready = 1'b1;
        chk("s3_frm_cnt", 32'(frm_cnt), 6);
        step();
        chk("s3_reads", 32'(rd_cnt - rb), 160);
        chk("s3_rd_viol", 32'(rd_viol - vwb), 0);
        chk_frame(vb, 800, "s3");

        // 4: en dropped after 50 reads
        vb = vq.size();
        rb = rd_cnt;
        wr_n(HOP);
        n = 0;
        while (rd_cnt - rb < 50 && n < 1000) begin
            step();
            n++;
        end
        chk("s4_reach50", 32'(rd_cnt - rb >= 50), 1);
        en = 1'b0;
        wait_frm(7, "s4_frm_cnt");
        step();
        chk_frame(vb, 960, "s4");
        chk("s4_busy", 32'(busy), 0);
        ib = init_cnt;
        wr_n(HOP);
        repeat (5) step();
        chk("s4_no_init", 32'(init_cnt - ib), 0);
        chk("s4_busy_idle", 32'(busy), 0);
        chk("s4_frm_hold", 32'(frm_cnt), 7);

        // 5: reset mid-frame at read 80
        en = 1'b1;
        rb = rd_cnt;
        n = 0;
        while (rd_cnt - rb < 80 && n < 1000) begin
            step();
            n++;
        end
        chk("s5_reach80", 32'(rd_cnt - rb >= 80), 1);
        rst_n = 1'b0;
        step();
        chk("s5_frm_cnt", 32'(frm_cnt), 0);
        chk("s5_busy", 32'(busy), 0);
        chk("s5_valid", 32'(smp_valid), 0);
        chk("s5_rd_en", 32'(buf_rd_en), 0);
        chk("s5_init", 32'(buf_frm_init), 0);
        chk("s5_sop_eop", 32'({smp_sop, smp_eop}), 0);
        en = 1'b0;
        rst_n = 1'b1;
        step();
        chk("s5_valid_after", 32'(smp_valid), 0);
        chk("s5_busy_after", 32'(busy), 0);

        // 6: overflow flag
        force_full = 1'b1;
        src_wr = 1'b1;
        step();
        src_wr = 1'b0;
        force_full = 1'b0;
        step();
        chk("s6_ovf_set", 32'(ovf_err), 1);
        step();
        chk("s6_ovf_sticky", 32'(ovf_err), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("s6_ovf_clr", 32'(ovf_err), 0);
        src_wr = 1'b1;
        step();
        src_wr = 1'b0;
        chk("s6_wr_not_full", 32'(ovf_err), 0);
        force_full = 1'b1;
        src_wr = 1'b1;
        err_clr = 1'b1;
        step();
        force_full = 1'b0;
        src_wr = 1'b0;
        err_clr = 1'b0;
        chk("s6_set_wins", 32'(ovf_err), 1);
        step();
        chk("s6_set_hold", 32'(ovf_err), 1);

        // 6b: HOP_LENGTH=1 instance, sop and eop on one sample
        h1_en = 1'b1;
        seen = 0;
        se = 2'b00;
        n = 0;
        while (seen == 0 && n < 20) begin
            step();
            if (h1_valid) begin
                seen = 1;
                se = {h1_sop, h1_eop};
            end
            n++;
        end
        h1_en = 1'b0;
        chk("h1_seen", 32'(seen), 1);
        chk("h1_sop_eop", 32'(se), 3);
        step();
        chk("h1_frm_cnt", 32'(h1_frm_cnt), 1);
        chk("h1_idle", 32'(h1_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stft_frame_sched.md
Name: stft_frame_sched

Overview:
Frame scheduler that sequences the STFT circular sample buffer. It waits until a full analysis window is resident, pulses the buffer's frame-init, then issues exactly HOP_LENGTH reads per frame under downstream flow control. It tags the buffer's read data with valid/sop/eop, counts frames and flags source overflow. It sits between the buffer and the windowing/FFT front end and does not carry sample data itself.

Parameters:
WIN_LENGTH, 480, window length in samples; must match the buffer instance.
HOP_LENGTH, 160, samples consumed per frame; legal range 1 <= HOP_LENGTH <= WIN_LENGTH.
FCNT_WIDTH, 16, width of the frame counter.
ADDR_WIDTH, derived localparam clog2(2**clog2(WIN_LENGTH)), matches the buffer's count width (9 for defaults).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
en  in  1  run enable; level-sensitive
buf_count  in  ADDR_WIDTH  buffer occupancy (buffer count_r)
buf_empty  in  1  buffer empty
buf_full  in  1  buffer full
src_wr  in  1  copy of the source's buffer wr_en (monitor only)
dn_ready  in  1  downstream can accept a sample arriving next cycle
err_clr  in  1  clears ovf_err
buf_frm_init  out  1  one-cycle frame-init pulse to the buffer
buf_rd_en  out  1  buffer read enable
smp_valid  out  1  buffer dout valid this cycle
smp_sop  out  1  first sample of the frame (qualified by smp_valid)
smp_eop  out  1  last sample of the frame (qualified by smp_valid)
frm_cnt  out  FCNT_WIDTH  completed frames; wraps modulo 2**FCNT_WIDTH
busy  out  1  high in any state other than IDLE
ovf_err  out  1  sticky: write attempted while buffer full

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, state goes to IDLE. All outputs are 0 and the hop counter is 0. Read data in flight is dropped (smp_valid=0 the next cycle).
- States: IDLE, PRIME, INIT, READ, GAP.
- IDLE: en=1 -> PRIME.
- PRIME: wait for buf_count >= WIN_LENGTH, then -> INIT. en=0 while in PRIME -> IDLE.
- INIT: buf_frm_init=1 for exactly this cycle; clear the hop counter; -> READ.
- READ: buf_rd_en = dn_ready & ~buf_empty, combinational from the registered state.
  - Each issued read increments the hop counter (0..HOP_LENGTH-1).
  - The read issued at hop counter HOP_LENGTH-1 -> GAP.
  - en=0 during READ does not abort; the frame always completes.
- GAP: one cycle with no reads. frm_cnt increments. Then -> PRIME if en=1, else -> IDLE.
- Latency: buffer dout is registered, one cycle after buf_rd_en.
  - smp_valid = buf_rd_en delayed 1 cycle.
  - smp_sop = read issued with hop counter 0, delayed 1 cycle.
  - smp_eop = read issued with hop counter HOP_LENGTH-1, delayed 1 cycle.
  - HOP_LENGTH=1: sop and eop are asserted together.
- dn_ready is a one-cycle credit. Once a read is issued, the sample is delivered the next cycle regardless of dn_ready, so downstream must hold space when asserting it.
- Minimum frame period is HOP_LENGTH+3 cycles (INIT, READ x HOP, GAP, PRIME check), given WIN_LENGTH already resident.
- Every frame starts only with buf_count >= WIN_LENGTH, which retains WIN_LENGTH-HOP_LENGTH samples of overlap. The buf_empty gate is defensive.
- ovf_err: set on src_wr & buf_full; cleared by err_clr. If both occur in the same cycle, set wins.
- frm_cnt wraps from all-ones to 0 with no flag.

Decomposition:
- Shared package mel_pkg holds:
  - the state enum (IDLE/PRIME/INIT/READ/GAP);
  - default WIN_LENGTH/HOP_LENGTH constants, shared with the buffer;
  - a clog2-based ADDR_WIDTH helper.
- No sub-module: the hop counter and the 1-cycle tag pipeline are inline. The bench instantiates this block together with the buffer.

Test Plan:
1. Basic frame: en=1, write 480 samples 0..479, dn_ready=1. Required:
   - one buf_frm_init pulse, then 160 contiguous reads;
   - smp_valid with sop on sample 0 and eop on sample 159;
   - frm_cnt=1; block then waits in PRIME with buf_count=320.
2. Steady state: stream 160 more samples per frame for 5 frames. Required:
   - frm_cnt=5;
   - each frame starts only once buf_count >= 480;
   - first sample of frame k is 160*k.
3. Backpressure: toggle dn_ready 1 cycle on, 2 off during READ. Required:
   - buf_rd_en only in dn_ready cycles;
   - exactly 160 valids, no duplicates or gaps in sample order.
4. en drop: deassert en mid-READ at read 50. Required:
   - remaining 110 reads complete and frm_cnt increments;
   - then IDLE, busy=0, no further frm_init.
5. Reset mid-frame: rst_n=0 for one edge at read 80. Required:
   - next cycle all outputs 0, state IDLE, frm_cnt=0, no stray smp_valid.
6. Overflow and edge case:
   - src_wr=1 with buf_full=1 -> ovf_err=1 and stays set; err_clr -> 0;
   - err_clr coincident with a new overflow -> ovf_err stays 1;
   - rerun scenario 1 with HOP_LENGTH=1 -> sop and eop on the same sample.
